// File: rtl/crc_pkg.sv
// Shared types and width helpers for the CRC calculator and its frame transmitter.
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSend
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Counter width for n states; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned frame_width(input int unsigned dwidth,
                                              input int unsigned crc_width);
    return dwidth + crc_width;
  endfunction

  function automatic int unsigned num_symbols(input int unsigned frame_w,
                                              input int unsigned sym_width);
    return frame_w / sym_width;
  endfunction

endpackage

// File: rtl/crc_sym_serializer.sv
// Parallel-load shift register that emits a frame MSB-first as valid/ready symbols.
module crc_sym_serializer
  import crc_pkg::*;
#(
  parameter int unsigned FRAME_W   = 24,
  parameter int unsigned SYM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 load_i,
  input  logic [FRAME_W-1:0]   frame_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [SYM_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int unsigned NSym = num_symbols(FRAME_W, SYM_WIDTH);
  localparam int unsigned CntW = cnt_width(NSym);
  localparam logic [CntW-1:0] LastCnt = CntW'(NSym - 1);

  logic [FRAME_W-1:0]   frame_q, frame_d, frame_shift;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [SYM_WIDTH-1:0] data_q, data_d;

  assign frame_shift = frame_q << SYM_WIDTH;

  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      frame_d = frame_i;
      cnt_d   = '0;
      valid_d = 1'b1;
      data_d  = frame_i[FRAME_W-1 -: SYM_WIDTH];
      last_d  = (NSym == 1);
    end else if (valid_q && ready_i) begin
      frame_d = frame_shift;
      if (last_q) begin
        // Counter parks at the last index instead of wrapping.
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        data_d = frame_shift[FRAME_W-1 -: SYM_WIDTH];
        last_d = (cnt_d == LastCnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign done_o  = valid_q & ready_i & last_q;

endmodule

// File: rtl/crc_frame_tx.sv
// Captures {data, crc} from the CRC calculator and streams it out as symbols.
// Optional sticky load-while-sending error flag: define CRC_FRAME_TX_OVF_EN.
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH = 8,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned SYM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 ctrlEn,
  input  logic [DWIDTH-1:0]    dataIn,
  input  logic [CRC_WIDTH-1:0] crcSeq,
  input  logic                 crcReady,
  output logic                 busy,
`ifdef CRC_FRAME_TX_OVF_EN
  input  logic                 ovfClr,
  output logic                 ovfErr,
`endif
  output logic                 txValid,
  input  logic                 txReady,
  output logic [SYM_WIDTH-1:0] txData,
  output logic                 txLast
);

  localparam int unsigned FrameW = frame_width(DWIDTH, CRC_WIDTH);

  if ((FrameW % SYM_WIDTH) != 0) begin : g_bad_sym_width
    $error("crc_frame_tx: DWIDTH+CRC_WIDTH must be a multiple of SYM_WIDTH");
  end

  state_e            state_q;
  logic [DWIDTH-1:0] data_q;
  logic              crc_ready_q;
  logic              busy_q;
  logic              crc_done;
  logic              load;
  logic              sym_done;

  assign crc_done = crcReady & ~crc_ready_q;
  // A load coinciding with done means a newer result is still pending.
  assign load     = (state_q == StCalc) & crc_done & ~ctrlEn;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      data_q      <= '0;
      crc_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      crc_ready_q <= crcReady;
      unique case (state_q)
        StIdle: begin
          if (ctrlEn) begin
            data_q  <= dataIn;
            state_q <= StCalc;
            busy_q  <= 1'b1;
          end
        end
        StCalc: begin
          if (ctrlEn) begin
            data_q <= dataIn;
          end else if (crc_done) begin
            state_q <= StSend;
          end
        end
        StSend: begin
          if (sym_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  crc_sym_serializer #(
    .FRAME_W  (FrameW),
    .SYM_WIDTH(SYM_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rstN   (rstN),
    .load_i (load),
    .frame_i({data_q, crcSeq}),
    .ready_i(txReady),
    .valid_o(txValid),
    .data_o (txData),
    .last_o (txLast),
    .done_o (sym_done)
  );

  assign busy = busy_q;

`ifdef CRC_FRAME_TX_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_q <= 1'b0;
    end else if ((state_q == StSend) && ctrlEn) begin
      ovf_q <= 1'b1;
    end else if (ovfClr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovfErr = ovf_q;
`endif

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
- Downstream stage of the parallel CRC calculator.
- Snoops the calculator's load strobe and data word, and captures the CRC result when the calculator signals completion.
- Serializes the frame {data, crc}, MSB first, in SYM_WIDTH-bit symbols over a valid/ready stream to the link/PHY side.
- Drives busy back upstream so the controller holds off new loads while a frame is in flight.

Parameters:
- CRC_WIDTH, 8: CRC width; must match the calculator.
- DWIDTH, 16: data word width; must match the calculator.
- SYM_WIDTH, 8: output symbol width. (DWIDTH+CRC_WIDTH) must be an integer multiple of SYM_WIDTH; otherwise elaboration error.

Ports:
- clk, input, 1: clock.
- rstN, input, 1: reset, asynchronous, active-low.
- ctrlEn, input, 1: load strobe, the same net that drives the calculator.
- dataIn, input, DWIDTH: data word, the same net that drives the calculator.
- crcSeq, input, CRC_WIDTH: CRC result from the calculator.
- crcReady, input, 1: calculator ready; 0 while calculating.
- busy, output, 1: a frame is captured or in flight; upstream must not pulse ctrlEn while busy=1.
- txValid, output, 1: txData holds a valid symbol.
- txReady, input, 1: sink accepts the symbol.
- txData, output, SYM_WIDTH: current symbol.
- txLast, output, 1: marks the final symbol of the frame.

Behaviour:
- Reset (async, rstN=0): state=IDLE; busy=0, txValid=0, txLast=0, txData=0; frame register=0; symbol counter=0; crcReady delay register=1. Reset mid-frame aborts the frame silently.
- Constants: FRAME_W=DWIDTH+CRC_WIDTH; NSYM=FRAME_W/SYM_WIDTH (default 3).
- Done event: crcDone = crcReady & ~crcReadyD. crcReadyD is crcReady registered.
- Timing chain:
  - ctrlEn sampled at edge N → calculator result registered at edge N+1 → crcDone high in the cycle after N+1.
  - Frame captured and SEND entered at edge N+2; txValid=1 from edge N+2.
- State IDLE (busy=0):
  - ctrlEn=1 → latch dataIn into the data field; go to CALC.
- State CALC (busy=1):
  - ctrlEn=1 again (back-to-back or held) → re-latch dataIn, last wins, mirroring the calculator's recalculation.
  - crcDone=1 with ctrlEn=0 → frame register={data, crcSeq}; counter=0; go to SEND.
  - crcDone=1 with ctrlEn=1 in the same cycle → re-latch data, stay in CALC (a new result is pending).
- State SEND (busy=1):
  - txValid=1; txData=frame[FRAME_W-1 -: SYM_WIDTH]; txLast=(counter==NSYM-1).
  - On txValid&txReady: shift frame left by SYM_WIDTH (zero-fill); counter+1.
  - Handshake on the last symbol → txValid=0, txLast=0, go to IDLE. busy drops the same edge, so a new ctrlEn is accepted from the next cycle.
  - txReady=0 → txData, txLast and txValid hold stable; no symbol is dropped or duplicated.
  - ctrlEn=1 in SEND → ignored; frame unaffected; protocol violation.
- txData is registered, not a combinational slice to the port. All outputs are registered.
- Counter width is clog2(NSYM), minimum 1; it never wraps past NSYM-1.

Optional Feature:
- Macro CRC_FRAME_TX_OVF_EN.
- Defined:
  - Adds output ovfErr (1 bit, reset 0) and input ovfClr (1 bit).
  - ovfErr is set sticky by ctrlEn=1 while state=SEND; it is cleared by ovfClr=1.
  - If ovfClr and a set condition occur in the same cycle, set wins.
- Not defined: neither port exists; ctrlEn in SEND is silently ignored.

Decomposition:
- Package crc_pkg: state enum (IDLE, CALC, SEND), FRAME_W/NSYM derivation function, clog2 function shared with the calculator.
- One natural sub-module, crc_sym_serializer: a parallel-load shift register with counter and valid/ready/last, parameterized by FRAME_W/SYM_WIDTH.
- The top holds the FSM, capture and done detection.

Test Plan:
1. Basic frame: dataIn=0x1234, ctrlEn pulse at edge N, bench model drives crcSeq=0xA5 at N+1, txReady=1 → txValid from N+2; symbols 0x12, 0x34, 0xA5; txLast only on 0xA5; busy low after the 3rd handshake.
2. Backpressure: same frame with txReady=0 for 4 cycles on symbol 0x34 → txData holds 0x34, txValid stays 1, then 0xA5 follows. Exactly 3 handshakes total.
3. Back-to-back load in CALC: ctrlEn at N (0x1111) and N+1 (0x2222), crcSeq=0x3C → frame 0x22, 0x22, 0x3C.
4. Load during SEND: ctrlEn with dataIn=0xFFFF mid-frame → current frame intact. With the macro, ovfErr=1 until ovfClr; without it, no effect.
5. Reset mid-frame: rstN low after the first symbol → all outputs 0 immediately (asynchronous). After release, a new 0xBEEF/0x5A frame is sent correctly.
6. Params CRC_WIDTH=16, DWIDTH=32, SYM_WIDTH=16: data 0xDEADBEEF, crc 0x1D0F → symbols 0xDEAD, 0xBEEF, 0x1D0F, txLast on the third.
